// File: rtl/bidirectional_shift_register_pkg.sv
// Shared definitions for the bidirectional shift register and its bench.
package bidirectional_shift_register_pkg;

  // Encoding of the dir input: 1 shifts toward the MSB, 0 toward the LSB.
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_e;

endpackage

// File: rtl/bidirectional_shift_register.sv
// Serial-in, parallel-out shift register with per-edge direction select.
// Every non-reset edge shifts one position and inserts data at the vacated end.
module bidirectional_shift_register
  import bidirectional_shift_register_pkg::*;
#(
  parameter int unsigned DATA_WID = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data,
  input  logic                dir,
  output logic [DATA_WID-1:0] out
);

  logic [DATA_WID-1:0] shift_q;
  logic [DATA_WID-1:0] shift_d;

  // Next-state mux: left inserts at bit 0, right inserts at the MSB.
  always_comb begin
    shift_d = shift_q;
    if (dir == DIR_LEFT) begin
      shift_d = {shift_q[DATA_WID-2:0], data};
    end else begin
      shift_d = {data, shift_q[DATA_WID-1:1]};
    end
  end

  // State register; synchronous reset takes priority over shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign out = shift_q;

endmodule

// File: tb/tb_bidirectional_shift_register.sv
// Self-checking bench: shadow-model scoreboard for an 8-bit and a 4-bit instance.
module tb_bidirectional_shift_register;
  import bidirectional_shift_register_pkg::*;

  logic       clk;
  logic       rst8, data8, dir8;
  logic [7:0] out8;
  logic       rst4, data4, dir4;
  logic [3:0] out4;

  logic [7:0] m8;
  logic [3:0] m4;
  logic [7:0] q8[$];
  logic [3:0] q4[$];
  logic [7:0] exp8;
  logic [3:0] exp4;

  int n_cmp;
  int n_err;

  bidirectional_shift_register #(.DATA_WID(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst8),
    .data (data8),
    .dir  (dir8),
    .out  (out8)
  );

  bidirectional_shift_register #(.DATA_WID(4)) u_dut4 (
    .clk  (clk),
    .rst  (rst4),
    .data (data4),
    .dir  (dir4),
    .out  (out4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one edge on the 8-bit DUT, push the model's expected result,
  // then wait until just after the edge so the caller can compare.
  task automatic drive8(input logic r, input logic d, input logic dr);
    @(negedge clk);
    rst8  = r;
    data8 = d;
    dir8  = dr;
    if (r) m8 = '0;
    else if (dr == DIR_LEFT) m8 = {m8[6:0], d};
    else m8 = {d, m8[7:1]};
    q8.push_back(m8);
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic r, input logic d, input logic dr);
    @(negedge clk);
    rst4  = r;
    data4 = d;
    dir4  = dr;
    if (r) m4 = '0;
    else if (dr == DIR_LEFT) m4 = {m4[2:0], d};
    else m4 = {d, m4[3:1]};
    q4.push_back(m4);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] want;
    for (int i = 0; i < 2; i++) begin
      drive8(1'b1, 1'b1, DIR_LEFT);
      exp8 = q8.pop_front();
      want = 8'h00;
      n_cmp++;
      if (out8 !== exp8 || out8 !== want) begin
        n_err++;
        $display("FAIL reset edge%0d: got %h want %h", i, out8, want);
      end
    end
  endtask

  task automatic test_left_fill_drain();
    logic [7:0] drain [3];
    drain[0] = 8'hFE; drain[1] = 8'hFC; drain[2] = 8'hF8;
    drive8(1'b1, 1'b0, DIR_LEFT);
    void'(q8.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive8(1'b0, 1'b1, DIR_LEFT);
      exp8 = q8.pop_front();
      n_cmp++;
      if (out8 !== exp8) begin
        n_err++;
        $display("FAIL left_fill edge%0d: got %h want %h", i, out8, exp8);
      end
    end
    n_cmp++;
    if (out8 !== 8'h7F) begin
      n_err++;
      $display("FAIL left_fill_final: got %h want 7f", out8);
    end
    for (int i = 0; i < 3; i++) begin
      drive8(1'b0, 1'b0, DIR_LEFT);
      exp8 = q8.pop_front();
      n_cmp++;
      if (out8 !== exp8 || out8 !== drain[i]) begin
        n_err++;
        $display("FAIL left_drain edge%0d: got %h want %h", i, out8, drain[i]);
      end
    end
  endtask

  task automatic test_right_fill();
    logic [7:0] want [3];
    want[0] = 8'h80; want[1] = 8'hC0; want[2] = 8'hE0;
    drive8(1'b1, 1'b0, DIR_RIGHT);
    void'(q8.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive8(1'b0, 1'b1, DIR_RIGHT);
      exp8 = q8.pop_front();
      n_cmp++;
      if (out8 !== exp8 || out8 !== want[i]) begin
        n_err++;
        $display("FAIL right_fill edge%0d: got %h want %h", i, out8, want[i]);
      end
    end
  endtask

  task automatic test_dir_switch();
    logic [7:0] want [6];
    want[0] = 8'h01; want[1] = 8'h02; want[2] = 8'h04;
    want[3] = 8'h02; want[4] = 8'h01; want[5] = 8'h00;
    drive8(1'b1, 1'b0, DIR_LEFT);
    void'(q8.pop_front());
    for (int i = 0; i < 6; i++) begin
      if (i == 0)     drive8(1'b0, 1'b1, DIR_LEFT);
      else if (i < 3) drive8(1'b0, 1'b0, DIR_LEFT);
      else            drive8(1'b0, 1'b0, DIR_RIGHT);
      exp8 = q8.pop_front();
      n_cmp++;
      if (out8 !== exp8 || out8 !== want[i]) begin
        n_err++;
        $display("FAIL dir_switch edge%0d: got %h want %h", i, out8, want[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] pat;
    pat = 8'hA5;
    drive8(1'b1, 1'b0, DIR_LEFT);
    void'(q8.pop_front());
    for (int i = 7; i >= 0; i--) begin
      drive8(1'b0, pat[i], DIR_LEFT);
      void'(q8.pop_front());
    end
    n_cmp++;
    if (out8 !== 8'hA5) begin
      n_err++;
      $display("FAIL mid_load: got %h want a5", out8);
    end
    drive8(1'b1, 1'b1, DIR_LEFT);
    exp8 = q8.pop_front();
    n_cmp++;
    if (out8 !== exp8 || out8 !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset: got %h want 00", out8);
    end
    drive8(1'b0, 1'b1, DIR_LEFT);
    exp8 = q8.pop_front();
    n_cmp++;
    if (out8 !== exp8 || out8 !== 8'h01) begin
      n_err++;
      $display("FAIL mid_resume: got %h want 01", out8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      drive8(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));
      exp8 = q8.pop_front();
      n_cmp++;
      if (out8 !== exp8) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i, out8, exp8);
      end
    end
  endtask

  task automatic test_width4();
    logic [3:0] want [5];
    want[0] = 4'h1; want[1] = 4'h3; want[2] = 4'h7; want[3] = 4'hF; want[4] = 4'hF;
    drive4(1'b1, 1'b1, DIR_LEFT);
    exp4 = q4.pop_front();
    n_cmp++;
    if (out4 !== exp4 || out4 !== 4'h0) begin
      n_err++;
      $display("FAIL w4_reset: got %h want 0", out4);
    end
    for (int i = 0; i < 5; i++) begin
      drive4(1'b0, 1'b1, DIR_LEFT);
      exp4 = q4.pop_front();
      n_cmp++;
      if (out4 !== exp4 || out4 !== want[i]) begin
        n_err++;
        $display("FAIL w4_fill edge%0d: got %h want %h", i, out4, want[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive4(1'b0, (i == 0), DIR_RIGHT);
      exp4 = q4.pop_front();
      n_cmp++;
      if (out4 !== exp4) begin
        n_err++;
        $display("FAIL w4_right edge%0d: got %h want %h", i, out4, exp4);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m8 = '0;
    m4 = '0;
    rst8 = 1'b1; data8 = 1'b0; dir8 = DIR_LEFT;
    rst4 = 1'b1; data4 = 1'b0; dir4 = DIR_LEFT;
    test_reset();
    test_left_fill_drain();
    test_right_fill();
    test_dir_switch();
    test_reset_midstream();
    test_back_to_back();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bidirectional_shift_register.md
Name: bidirectional_shift_register

Overview:
Serial-in, parallel-out shift register with a selectable shift direction.
- Each rising clock edge shifts the register one position and inserts the serial input bit at the vacated end.
- The direction is chosen by a control bit sampled on that edge.
- Used as a generic serial-to-parallel/pattern-generation stage; the full register contents are always visible on the parallel output.

Parameters:
DATA_WID, 8, register width in bits (legal range 2..64).

Ports:
clk   input  1         rising-edge clock; sole clock domain
rst   input  1         synchronous reset, active-high
data  input  1         serial input bit, inserted on each shift
dir   input  1         shift direction: 1 = left (toward MSB), 0 = right (toward LSB)
out   output DATA_WID  parallel register contents

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. No asynchronous paths.
- Reset:
  - rst=1 at a rising clk edge forces out to all-zeros on that edge.
  - Reset has priority over shifting, regardless of data/dir.
  - The register holds no other state.
- Shift left (dir=1, rst=0): out_next = {out[DATA_WID-2:0], data}.
  - data enters bit 0.
  - Bit DATA_WID-1 is discarded.
- Shift right (dir=0, rst=0): out_next = {data, out[DATA_WID-1:1]}.
  - data enters bit DATA_WID-1.
  - Bit 0 is discarded.
- A shift occurs on every non-reset edge. There is no enable and no hold state.
- Latency: one cycle. out reflects the inputs sampled at the most recent rising edge. out is a pure register output with no combinational path from data/dir/rst.
- dir may change on any cycle. Each edge uses only the dir value present at that edge, with no memory of the previous direction.
- Reset mid-operation: the register contents are lost. Shifting resumes from zero on the first edge with rst=0.
- X handling: data or dir unknown at an edge is a bench error. The RTL need not mask it.
- Inputs are synchronous to clk; no internal synchronisers.

Decomposition:
- Shared package: direction constants DIR_RIGHT=1'b0 and DIR_LEFT=1'b1. Bench and RTL both use these.
- No sub-module; a single always-block register with a two-way next-state mux.
- The bench adds a reference model (shadow register updated with the same rules) and a per-cycle compare.

Test Plan:
- Reset: rst=1 for 2 edges with data=1, dir=1 -> out=8'h00 after first edge and stays 8'h00.
- Left fill then drain:
  - From 8'h00, data=1, dir=1 for 7 edges -> out=8'h7F.
  - Then data=0, dir=1 for 3 edges -> 8'hFE, 8'hFC, 8'hF8.
- Right fill: from 8'h00, data=1, dir=0 for 3 edges -> 8'h80, 8'hC0, 8'hE0.
- Direction switch: load 8'h01 (reset, then one left shift with data=1).
  - dir=1, data=0 for 2 edges -> 8'h04.
  - Then dir=0, data=0 for 3 edges -> 8'h00 (bit shifted out of LSB, not wrapped).
- Reset mid-stream: out=8'hA5, rst=1 with data=1, dir=1 on one edge -> out=8'h00. Next edge with rst=0, data=1, dir=1 -> 8'h01.
- Width variant: DATA_WID=4, data=1, dir=1 for 5 edges from reset -> 4'h1, 4'h3, 4'h7, 4'hF, 4'hF (saturating fill, no overflow artefacts).
